// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit feeding a one-entry decode buffer.
// Handles branch/jump redirects, including discarding a response that went stale.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [XLEN-1:0] PcStep  = XLEN'(4);
  localparam logic [XLEN-1:0] CntStep = XLEN'(1);
  localparam logic [XLEN-1:0] NopWord = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StFull,
    StDrain
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            misalign_q, misalign_d;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pcplus4_d  = pcplus4_q;
    count_d    = count_q;
    misalign_d = 1'b0;

    unique case (state_q)
      StReq: begin
        if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          instr_d    = imem_rdata;
          pc_d       = fetch_pc_q;
          pcplus4_d  = fetch_pc_q + PcStep;
          fetch_pc_d = fetch_pc_q + PcStep;
          state_d    = StFull;
        end
      end
      StFull: begin
        if (instr_ready) begin
          count_d = count_q + CntStep;
          state_d = StReq;
        end
      end
      StDrain: begin
        if (imem_rsp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    // Redirect overrides everything except the consume count taken in StFull above.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
      instr_d    = instr_q;
      pc_d       = pc_q;
      pcplus4_d  = pcplus4_q;
      unique case (state_q)
        StReq:   state_d = imem_req_ready ? StDrain : StReq;
        // A response arriving alongside the redirect is the outstanding one; drop it here.
        StWait:  state_d = imem_rsp_valid ? StReq : StDrain;
        StFull:  state_d = StReq;
        StDrain: state_d = imem_rsp_valid ? StReq : StDrain;
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NopWord;
      pc_q       <= RESET_PC;
      pcplus4_q  <= RESET_PC + PcStep;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pcplus4_q  <= pcplus4_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Gated by reset so no request is offered while the unit is held in reset.
  assign imem_req_valid = (state_q == StReq) && !reset;
  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = (state_q == StFull);
  assign Instr          = instr_q;
  assign PC             = pc_q;
  assign PCPlus4        = pcplus4_q;
  assign misalign_err   = misalign_q;
  assign fetch_count    = count_q;

endmodule
